nabp_sinogram_reader: RTL and testbench

Host-side responder for the filtered-RAM fill interface. It sequences projection angles for one reconstruction frame and answers the angle handshake (`hs_next_angle` / `hs_next_angle_ack`). It also serves sinogram samples: an address made of the current angle and the requested signed `hs_s_val` is turned into a read of external sinogram memory, and the sample is returned on `hs_val` after a fixed latency. `hs_val` feeds the FIR filter ahead of the swap control.

---
 rtl/nabp_sinogram_reader_if.sv | 35 +++
 rtl/nabp_sinogram_reader.sv | 165 ++++++++++++++++
 tb/tb_nabp_sinogram_reader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nabp_sinogram_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : nabp_sinogram_reader_if
//  Description : Angle handshake and sinogram-memory bus between the swap
//                control / memory and the sinogram reader.
//  Revision    : 1.0  initial release
// ============================================================================
interface nabp_sinogram_reader_if #(
    parameter int A_LEN    = 8,
    parameter int S_LEN    = 9,
    parameter int DATA_LEN = 12
);
    logic                          hs_next_angle;
    logic signed [S_LEN-1:0]       hs_s_val;
    logic [A_LEN-1:0]              hs_angle;
    logic                          hs_has_next_angle;
    logic                          hs_next_angle_ack;
    logic [DATA_LEN-1:0]           hs_val;
    logic                          mem_rd;
    logic [A_LEN+S_LEN-1:0]        mem_addr;
    logic [DATA_LEN-1:0]           mem_data;

    modport master (
        output hs_next_angle, hs_s_val, mem_data,
        input  hs_angle, hs_has_next_angle, hs_next_angle_ack, hs_val,
               mem_rd, mem_addr
    );

    modport slave (
        input  hs_next_angle, hs_s_val, mem_data,
        output hs_angle, hs_has_next_angle, hs_next_angle_ack, hs_val,
               mem_rd, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/nabp_sinogram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : nabp_sinogram_reader
//  Description : Sequences projection angles for one frame and serves
//                sinogram samples from external memory at fixed latency.
//  Revision    : 1.0  initial release
// ============================================================================
module nabp_sinogram_reader #(
    parameter int A_LEN      = 8,
    parameter int S_LEN      = 9,
    parameter int DATA_LEN   = 12,
    parameter int N_ANGLES   = 180,
    parameter int ANGLE_STEP = 1,
    parameter int S_SIZE     = 256,
    parameter int MEM_LAT    = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    nabp_sinogram_reader_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_SERVE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [A_LEN-1:0]        c_step       = A_LEN'(ANGLE_STEP);
    localparam logic [A_LEN:0]          c_step_w     = (A_LEN+1)'(ANGLE_STEP);
    localparam logic [A_LEN:0]          c_n_angles   = (A_LEN+1)'(N_ANGLES);
    localparam logic                    c_first_next = (c_step_w < c_n_angles);
    localparam logic signed [S_LEN:0]   c_half       = (S_LEN+1)'(S_SIZE / 2);
    localparam logic signed [S_LEN:0]   c_size       = (S_LEN+1)'(S_SIZE);

    state_t                 r_state, w_state_next;
    logic [A_LEN-1:0]       r_angle, w_angle_next;
    logic                   r_has_next, w_has_next_next;
    logic                   r_ack, w_ack_next;
    logic                   r_done, w_done_next;
    logic [A_LEN-1:0]       w_angle_inc;
    logic                   w_has_next_calc;
    logic                   w_busy;

    assign w_busy          = (r_state != S_IDLE);
    // Widened by one bit so angle+step never wraps before the compare.
    assign w_angle_inc     = r_angle + c_step;
    assign w_has_next_calc = (({1'b0, w_angle_inc} + c_step_w) < c_n_angles);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_angle    <= '0;
            r_has_next <= 1'b0;
            r_ack      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_angle    <= w_angle_next;
            r_has_next <= w_has_next_next;
            r_ack      <= w_ack_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_angle_next    = r_angle;
        w_has_next_next = r_has_next;
        w_ack_next      = 1'b0;
        w_done_next     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next    = S_FIRST;
                    w_angle_next    = '0;
                    w_has_next_next = c_first_next;
                    w_ack_next      = 1'b1;
                end
            end
            S_FIRST: begin
                w_state_next = S_SERVE;
            end
            S_SERVE: begin
                // A request seen while the ack is still showing is the same request.
                if (bus.hs_next_angle && !r_ack) begin
                    if (r_has_next) begin
                        w_angle_next    = w_angle_inc;
                        w_has_next_next = w_has_next_calc;
                        w_ack_next      = 1'b1;
                    end else begin
                        w_state_next = S_FINISH;
                        w_done_next  = 1'b1;
                    end
                end
            end
            S_FINISH: begin
                w_state_next    = S_IDLE;
                w_angle_next    = '0;
                w_has_next_next = 1'b0;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    logic signed [S_LEN:0]      w_s_ext;
    logic signed [S_LEN:0]      w_u;
    logic                       w_oor;
    logic                       r_mem_rd;
    logic [A_LEN+S_LEN-1:0]     r_mem_addr;
    logic                       w_vld_out;
    logic [DATA_LEN-1:0]        r_hs_val;

    assign w_s_ext = {bus.hs_s_val[S_LEN-1], bus.hs_s_val};
    assign w_u     = w_s_ext + c_half;
    assign w_oor   = w_u[S_LEN] || (w_u >= c_size);

    // Angle is captured alongside the address so later swaps cannot disturb reads in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_mem_rd   <= !w_oor && w_busy;
            r_mem_addr <= {r_angle, w_u[S_LEN-1:0]};
        end
    end

    generate
        if (MEM_LAT == 1) begin : g_lat_one
            logic r_vld_sr;
            always_ff @(posedge clk) begin
                if (!reset_n) r_vld_sr <= 1'b0;
                else          r_vld_sr <= r_mem_rd;
            end
            assign w_vld_out = r_vld_sr;
        end else begin : g_lat_multi
            logic [MEM_LAT-1:0] r_vld_sr;
            always_ff @(posedge clk) begin
                if (!reset_n) r_vld_sr <= '0;
                else          r_vld_sr <= {r_vld_sr[MEM_LAT-2:0], r_mem_rd};
            end
            assign w_vld_out = r_vld_sr[MEM_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) r_hs_val <= '0;
        else          r_hs_val <= (w_vld_out && w_busy) ? bus.mem_data : '0;
    end

    assign bus.hs_angle          = r_angle;
    assign bus.hs_has_next_angle = r_has_next;
    assign bus.hs_next_angle_ack = r_ack;
    assign bus.hs_val            = r_hs_val;
    assign bus.mem_rd            = r_mem_rd;
    assign bus.mem_addr          = r_mem_addr;
    assign busy                  = w_busy;
    assign done                  = r_done;
endmodule
`default_nettype wire

// File: tb/tb_nabp_sinogram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nabp_sinogram_reader
//  Description : Self-checking bench: angle sequencing, data latency, range
//                clamping, held requests and mid-frame reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nabp_sinogram_reader;
    localparam int A_LEN    = 8;
    localparam int S_LEN    = 9;
    localparam int DATA_LEN = 12;
    localparam int AW       = A_LEN + S_LEN;

    logic clk;
    logic reset_n;
    logic start_a, start_b;
    logic busy_a, busy_b, done_a, done_b;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    typedef struct { int due; logic [DATA_LEN-1:0] val; } val_exp_t;
    typedef struct { int due; logic rd; logic [AW-1:0] addr; logic chk_addr; } addr_exp_t;
    val_exp_t  val_q[$];
    addr_exp_t addr_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nabp_sinogram_reader_if #(.A_LEN(A_LEN), .S_LEN(S_LEN), .DATA_LEN(DATA_LEN)) ifa ();
    nabp_sinogram_reader_if #(.A_LEN(A_LEN), .S_LEN(S_LEN), .DATA_LEN(DATA_LEN)) ifb ();

    nabp_sinogram_reader #(.N_ANGLES(4)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a), .bus(ifa)
    );
    nabp_sinogram_reader u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b), .bus(ifb)
    );

    // One-cycle memory returning the low 12 address bits.
    always @(posedge clk) begin
        ifa.mem_data <= ifa.mem_addr[11:0];
        ifb.mem_data <= ifb.mem_addr[11:0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        ifa.hs_next_angle = 1'b0; ifa.hs_s_val = '0;
        ifb.hs_next_angle = 1'b0; ifb.hs_s_val = '0;
        tick(); tick();
        checks++;
        if ({ifa.hs_angle, ifa.hs_has_next_angle, ifa.hs_next_angle_ack, done_a, busy_a,
             ifa.mem_rd, ifa.mem_addr, ifa.hs_val} !== '0) begin
            errors++;
            $display("FAIL reset_a: angle=%0h has=%b ack=%b done=%b busy=%b rd=%b addr=%0h val=%0h, required all 0",
                     ifa.hs_angle, ifa.hs_has_next_angle, ifa.hs_next_angle_ack, done_a, busy_a,
                     ifa.mem_rd, ifa.mem_addr, ifa.hs_val);
        end
        checks++;
        if ({ifb.hs_angle, ifb.hs_has_next_angle, ifb.hs_next_angle_ack, done_b, busy_b,
             ifb.mem_rd, ifb.mem_addr, ifb.hs_val} !== '0) begin
            errors++;
            $display("FAIL reset_b: angle=%0h has=%b ack=%b done=%b busy=%b rd=%b addr=%0h val=%0h, required all 0",
                     ifb.hs_angle, ifb.hs_has_next_angle, ifb.hs_next_angle_ack, done_b, busy_b,
                     ifb.mem_rd, ifb.mem_addr, ifb.hs_val);
        end
    endtask

    task automatic test_idle();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ifa.hs_s_val = S_LEN'($urandom_range(0, 255) - 128);
            ifb.hs_s_val = S_LEN'($urandom_range(0, 255) - 128);
            tick();
            checks++;
            if ({ifa.hs_angle, ifa.hs_has_next_angle, ifa.hs_next_angle_ack, done_a, busy_a,
                 ifa.mem_rd, ifa.hs_val} !== '0) begin
                errors++;
                $display("FAIL idle_a cycle %0d: ack=%b done=%b busy=%b rd=%b val=%0h angle=%0h, required 0",
                         i, ifa.hs_next_angle_ack, done_a, busy_a, ifa.mem_rd, ifa.hs_val, ifa.hs_angle);
            end
            checks++;
            if ({ifb.hs_angle, ifb.hs_has_next_angle, ifb.hs_next_angle_ack, done_b, busy_b,
                 ifb.mem_rd, ifb.hs_val} !== '0) begin
                errors++;
                $display("FAIL idle_b cycle %0d: ack=%b done=%b busy=%b rd=%b val=%0h angle=%0h, required 0",
                         i, ifb.hs_next_angle_ack, done_b, busy_b, ifb.mem_rd, ifb.hs_val, ifb.hs_angle);
            end
        end
    endtask

    task automatic test_frame();
        ifa.hs_s_val = '0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        checks++;
        if ({ifa.hs_next_angle_ack, ifa.hs_angle, ifa.hs_has_next_angle, busy_a} !== {1'b1, 8'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL frame_first: ack=%b angle=%0d has=%b busy=%b, required 1 0 1 1",
                     ifa.hs_next_angle_ack, ifa.hs_angle, ifa.hs_has_next_angle, busy_a);
        end
        for (int k = 1; k <= 4; k++) begin
            repeat (4) begin
                tick();
                checks++;
                if (ifa.hs_next_angle_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_spurious_ack k=%0d: ack=%b, required 0", k, ifa.hs_next_angle_ack);
                end
            end
            ifa.hs_next_angle = 1'b1; tick(); ifa.hs_next_angle = 1'b0;
            if (k < 4) begin
                checks++;
                if ({ifa.hs_next_angle_ack, ifa.hs_angle, ifa.hs_has_next_angle, done_a} !==
                    {1'b1, 8'(k), (k < 3) ? 1'b1 : 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL frame_ack k=%0d: ack=%b angle=%0d has=%b done=%b, required 1 %0d %0d 0",
                             k, ifa.hs_next_angle_ack, ifa.hs_angle, ifa.hs_has_next_angle, done_a, k, (k < 3));
                end
            end else begin
                checks++;
                if ({ifa.hs_next_angle_ack, done_a, busy_a, ifa.hs_angle} !== {1'b0, 1'b1, 1'b1, 8'd3}) begin
                    errors++;
                    $display("FAIL frame_done: ack=%b done=%b busy=%b angle=%0d, required 0 1 1 3",
                             ifa.hs_next_angle_ack, done_a, busy_a, ifa.hs_angle);
                end
            end
        end
        tick();
        checks++;
        if ({done_a, busy_a} !== 2'b00) begin
            errors++;
            $display("FAIL frame_end: done=%b busy=%b, required 0 0", done_a, busy_a);
        end
    endtask

    task automatic test_data();
        int svals[8] = '{-128, 0, 127, -129, 128, -1, 55, -64};
        start_b = 1'b1; tick(); start_b = 1'b0; tick();
        repeat (2) begin
            ifb.hs_next_angle = 1'b1; tick(); ifb.hs_next_angle = 1'b0; tick();
        end
        checks++;
        if (ifb.hs_angle !== 8'd2) begin
            errors++;
            $display("FAIL data_setup_angle: angle=%0d, required 2", ifb.hs_angle);
        end
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                int  s  = svals[i];
                logic in_rng = (s >= -128) && (s <= 127);
                int  ea = 2 * 512 + ((s + 128) & 511);
                addr_exp_t ae;
                val_exp_t  ve;
                ifb.hs_s_val = S_LEN'(s);
                ae.due = cyc + 1; ae.rd = in_rng; ae.addr = AW'(ea); ae.chk_addr = in_rng;
                ve.due = cyc + 3; ve.val = in_rng ? DATA_LEN'(ea & 12'hFFF) : '0;
                addr_q.push_back(ae);
                val_q.push_back(ve);
            end else begin
                ifb.hs_s_val = '0;
            end
            tick();
            while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
                addr_exp_t e = addr_q.pop_front();
                checks++;
                if (ifb.mem_rd !== e.rd || (e.chk_addr && ifb.mem_addr !== e.addr)) begin
                    errors++;
                    $display("FAIL data_addr: rd=%b addr=%0h, required rd=%b addr=%0h", ifb.mem_rd, ifb.mem_addr, e.rd, e.addr);
                end
            end
            while (val_q.size() > 0 && val_q[0].due <= cyc) begin
                val_exp_t e = val_q.pop_front();
                checks++;
                if (ifb.hs_val !== e.val) begin
                    errors++;
                    $display("FAIL data_val: hs_val=%0h, required %0h", ifb.hs_val, e.val);
                end
            end
        end
        checks++;
        if (addr_q.size() != 0 || val_q.size() != 0) begin
            errors++;
            $display("FAIL data_drain: %0d addr and %0d val entries left, required 0", addr_q.size(), val_q.size());
        end
    endtask

    task automatic test_held_request();
        logic exp_ack[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            ifb.hs_next_angle = (i < 6);
            tick();
            checks++;
            if (ifb.hs_next_angle_ack !== exp_ack[i]) begin
                errors++;
                $display("FAIL held_ack step %0d: ack=%b, required %b", i, ifb.hs_next_angle_ack, exp_ack[i]);
            end
        end
        ifb.hs_next_angle = 1'b0;
        checks++;
        if (ifb.hs_angle !== 8'd5) begin
            errors++;
            $display("FAIL held_angle: angle=%0d, required 5", ifb.hs_angle);
        end
    endtask

    task automatic test_start_ignored();
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({ifb.hs_next_angle_ack, ifb.hs_angle, busy_b} !== {1'b0, 8'd5, 1'b1}) begin
                errors++;
                $display("FAIL start_ignored %0d: ack=%b angle=%0d busy=%b, required 0 5 1",
                         i, ifb.hs_next_angle_ack, ifb.hs_angle, busy_b);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        reset_n = 1'b0; tick();
        checks++;
        if ({ifb.hs_angle, ifb.hs_has_next_angle, ifb.hs_next_angle_ack, done_b, busy_b,
             ifb.mem_rd, ifb.mem_addr, ifb.hs_val} !== '0) begin
            errors++;
            $display("FAIL mid_reset: angle=%0h has=%b ack=%b done=%b busy=%b rd=%b addr=%0h val=%0h, required all 0",
                     ifb.hs_angle, ifb.hs_has_next_angle, ifb.hs_next_angle_ack, done_b, busy_b,
                     ifb.mem_rd, ifb.mem_addr, ifb.hs_val);
        end
        reset_n = 1'b1; tick();
        checks++;
        if ({busy_b, done_b} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_idle: busy=%b done=%b, required 0 0", busy_b, done_b);
        end
        start_b = 1'b1; tick(); start_b = 1'b0;
        checks++;
        if ({ifb.hs_next_angle_ack, ifb.hs_angle, ifb.hs_has_next_angle, busy_b} !== {1'b1, 8'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL restart: ack=%b angle=%0d has=%b busy=%b, required 1 0 1 1",
                     ifb.hs_next_angle_ack, ifb.hs_angle, ifb.hs_has_next_angle, busy_b);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame();
        test_data();
        test_held_request();
        test_start_ignored();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
